// File: rtl/sn76489_write_scheduler.sv
// SN76489 write front end: round-robin host/player arbitration,
// command-to-byte expansion and a fixed idle gap between strobes.
module sn76489_write_scheduler #(
    parameter int WRITE_GAP = 4,
    parameter int GAP_BITS  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       h_valid,
    output logic       h_ready,
    input  logic [1:0] h_type,
    input  logic [1:0] h_chan,
    input  logic [9:0] h_value,
    input  logic       p_valid,
    output logic       p_ready,
    input  logic [1:0] p_type,
    input  logic [1:0] p_chan,
    input  logic [9:0] p_value,
    output logic [7:0] data,
    output logic       web,
    output logic       busy,
    output logic       err,
    input  logic       err_clr,
    output logic       last_grant
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BYTE1,
        S_GAP1,
        S_BYTE2,
        S_GAP2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_tone;
    logic [5:0]          r_hi;
    logic [7:0]          r_data;
    logic [GAP_BITS-1:0] r_cnt;
    logic                r_err;
    logic                r_last;

    logic                w_idle;
    logic                w_gnt_h;
    logic                w_gnt_p;
    logic                w_accept;
    logic                w_illegal;
    logic                w_gap_done;
    logic [1:0]          w_type;
    logic [1:0]          w_chan;
    logic [9:0]          w_value;
    logic [7:0]          w_byte1;

    assign w_idle   = (r_state == S_IDLE);
    // On a tie the requester that did not win last time gets the slot
    assign w_gnt_h  = h_valid && (!p_valid || r_last);
    assign w_gnt_p  = p_valid && (!h_valid || !r_last);
    assign w_accept = w_idle && (h_valid || p_valid);

    assign w_type  = w_gnt_p ? p_type  : h_type;
    assign w_chan  = w_gnt_p ? p_chan  : h_chan;
    assign w_value = w_gnt_p ? p_value : h_value;

    assign w_illegal  = (w_type == 2'b11) ||
                        (w_type == 2'b00 && w_chan == 2'd3);
    assign w_gap_done = (r_cnt == GAP_BITS'(1));

    always_comb begin
        w_byte1 = 8'h00;
        case (w_type)
            2'b00:   w_byte1 = {1'b1, w_chan, 1'b0, w_value[3:0]};
            2'b01:   w_byte1 = {1'b1, w_chan, 1'b1, w_value[3:0]};
            2'b10:   w_byte1 = {5'b11100, w_value[2:0]};
            default: w_byte1 = 8'h00;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && !w_illegal) w_next = S_BYTE1;
            S_BYTE1: w_next = S_GAP1;
            S_GAP1:  if (w_gap_done) w_next = r_tone ? S_BYTE2 : S_IDLE;
            S_BYTE2: w_next = S_GAP2;
            S_GAP2:  if (w_gap_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tone  <= 1'b0;
            r_hi    <= 6'd0;
            r_data  <= 8'h00;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_tone <= (w_type == 2'b00);
                r_hi   <= w_value[9:4];
                r_last <= w_gnt_p;
                if (!w_illegal) r_data <= w_byte1;
            end
            if (r_state == S_GAP1 && w_gap_done && r_tone)
                r_data <= {2'b00, r_hi};
            if (r_state == S_BYTE1 || r_state == S_BYTE2)
                r_cnt <= GAP_BITS'(WRITE_GAP);
            else if (r_state == S_GAP1 || r_state == S_GAP2)
                r_cnt <= r_cnt - GAP_BITS'(1);
            if (w_accept && w_illegal)
                r_err <= 1'b1;
            else if (err_clr)
                r_err <= 1'b0;
        end
    end

    assign h_ready    = w_idle && w_gnt_h;
    assign p_ready    = w_idle && w_gnt_p;
    assign data       = r_data;
    assign web        = !(r_state == S_BYTE1 || r_state == S_BYTE2);
    assign busy       = !w_idle;
    assign err        = r_err;
    assign last_grant = r_last;

endmodule

// File: tb/tb_sn76489_write_scheduler.sv
// Directed bench for sn76489_write_scheduler: arbitration, encoding,
// strobe timing, illegal commands and mid-command reset.
module tb_sn76489_write_scheduler;

    localparam int WG = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       h_valid = 1'b0;
    logic       h_ready;
    logic [1:0] h_type = 2'b00;
    logic [1:0] h_chan = 2'b00;
    logic [9:0] h_value = 10'h000;
    logic       p_valid = 1'b0;
    logic       p_ready;
    logic [1:0] p_type = 2'b00;
    logic [1:0] p_chan = 2'b00;
    logic [9:0] p_value = 10'h000;
    logic [7:0] data;
    logic       web;
    logic       busy;
    logic       err;
    logic       err_clr = 1'b0;
    logic       last_grant;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sn76489_write_scheduler #(
        .WRITE_GAP(WG),
        .GAP_BITS (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .h_valid   (h_valid),
        .h_ready   (h_ready),
        .h_type    (h_type),
        .h_chan    (h_chan),
        .h_value   (h_value),
        .p_valid   (p_valid),
        .p_ready   (p_ready),
        .p_type    (p_type),
        .p_chan    (p_chan),
        .p_value   (p_value),
        .data      (data),
        .web       (web),
        .busy      (busy),
        .err       (err),
        .err_clr   (err_clr),
        .last_grant(last_grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        rst_n   = 1'b0;
        h_valid = 1'b0;
        p_valid = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_web", web, 1);
        chk("rst_data", data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_last", last_grant, 1);
        chk("rst_hready", h_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lows;
        reset_dut();

        // host attn ch1 value A
        h_valid = 1; h_type = 2'b01; h_chan = 2'd1; h_value = 10'h00A;
        #1;
        chk("attn_hready_N", h_ready, 1);
        chk("attn_pready_N", p_ready, 0);
        tick();
        chk("attn_web_N1", web, 0);
        chk("attn_data_N1", data, 8'hBA);
        chk("attn_busy_N1", busy, 1);
        chk("attn_last_N1", last_grant, 0);
        // next host command (tone ch2 2C5) waits through the gap
        h_type = 2'b00; h_chan = 2'd2; h_value = 10'h2C5;
        #1;
        chk("attn_hready_N1", h_ready, 0);
        for (int i = 0; i < WG; i++) begin
            tick();
            chk("attn_gap_web", web, 1);
            chk("attn_gap_data", data, 8'hBA);
            chk("attn_gap_hready", h_ready, 0);
        end
        tick();
        chk("attn_idle_busy", busy, 0);
        chk("tone_hready_N", h_ready, 1);

        // tone: strobes at N+1 and N+6, player waits until N+11
        tick();
        h_valid = 0;
        chk("tone_web_N1", web, 0);
        chk("tone_data_N1", data, 8'hC5);
        tick();
        p_valid = 1; p_type = 2'b01; p_chan = 2'd3; p_value = 10'h005;
        #1;
        chk("tone_pready_N2", p_ready, 0);
        chk("tone_web_N2", web, 1);
        for (int c = 3; c <= 10; c++) begin
            tick();
            chk("tone_busy", busy, 1);
            chk("tone_pready", p_ready, 0);
            chk("tone_web", web, (c == 6) ? 0 : 1);
            chk("tone_data", data, (c >= 6) ? 8'h2C : 8'hC5);
        end
        tick();
        chk("tone_idle_busy", busy, 0);
        chk("tone_idle_pready", p_ready, 1);
        chk("tone_idle_hready", h_ready, 0);
        tick();
        p_valid = 0;
        chk("pl_web", web, 0);
        chk("pl_data", data, 8'hF5);
        chk("pl_last", last_grant, 1);
        repeat (WG) tick();
        tick();
        chk("pl_idle", busy, 0);

        // both valid: host, player, host alternate every WG+2 cycles
        reset_dut();
        h_valid = 1; h_type = 2'b01; h_chan = 2'd0; h_value = 10'h001;
        p_valid = 1; p_type = 2'b01; p_chan = 2'd3; p_value = 10'h002;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rr_hready", h_ready, (k % 2 == 0) ? 1 : 0);
            chk("rr_pready", p_ready, (k % 2 == 1) ? 1 : 0);
            tick();
            chk("rr_web", web, 0);
            chk("rr_data", data, (k % 2 == 1) ? 8'hF2 : 8'h91);
            chk("rr_last", last_grant, k % 2);
            for (int i = 0; i < WG; i++) begin
                tick();
                chk("rr_gap_web", web, 1);
            end
            tick();
        end
        h_valid = 0;
        p_valid = 0;

        // player noise value 101
        p_valid = 1; p_type = 2'b10; p_chan = 2'd0; p_value = 10'h005;
        #1;
        chk("nz_pready", p_ready, 1);
        tick();
        p_valid = 0;
        chk("nz_web", web, 0);
        chk("nz_data", data, 8'hE5);
        repeat (WG) tick();
        tick();
        chk("nz_idle", busy, 0);

        // illegal commands: reserved type, then tone on ch3
        h_valid = 1; h_type = 2'b11; h_chan = 2'd0; h_value = 10'h000;
        #1;
        chk("ill_hready1", h_ready, 1);
        chk("ill_err0", err, 0);
        tick();
        chk("ill_err1", err, 1);
        chk("ill_web1", web, 1);
        chk("ill_busy1", busy, 0);
        h_type = 2'b00; h_chan = 2'd3; h_value = 10'h3FF;
        #1;
        chk("ill_hready2", h_ready, 1);
        tick();
        chk("ill_err2", err, 1);
        chk("ill_web2", web, 1);
        chk("ill_busy2", busy, 0);
        chk("ill_data", data, 8'hE5);
        h_valid = 0;
        err_clr = 1;
        tick();
        chk("ill_clr", err, 0);
        // clear and new error in the same cycle: error wins
        h_valid = 1; h_type = 2'b11;
        tick();
        chk("ill_setwins", err, 1);
        h_valid = 0;
        tick();
        chk("ill_clr2", err, 0);
        err_clr = 0;

        // reset between byte1 and byte2 of a tone
        h_valid = 1; h_type = 2'b00; h_chan = 2'd1; h_value = 10'h3FF;
        #1;
        chk("mr_hready", h_ready, 1);
        tick();
        h_valid = 0;
        chk("mr_web_N1", web, 0);
        chk("mr_data_N1", data, 8'hAF);
        tick();
        #2;
        rst_n = 0;
        #1;
        chk("mr_web", web, 1);
        chk("mr_data", data, 8'h00);
        chk("mr_busy", busy, 0);
        chk("mr_last", last_grant, 1);
        @(negedge clk);
        rst_n = 1;
        lows = 0;
        for (int i = 0; i < 2 * WG + 4; i++) begin
            tick();
            if (web !== 1'b1) lows++;
        end
        chk("mr_no_byte2", lows, 0);
        h_valid = 1; h_type = 2'b01;
        #1;
        chk("mr_ready_after", h_ready, 1);
        h_valid = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
